// File: rtl/lcd_pkg.sv
// Shared types for the LCD image controller.
//   cmd_e   : 4-bit host command codes
//   state_e : controller FSM states
//   win_idx : linear buffer address of a 2x2 window pixel
package lcd_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE = 4'h0,
    CMD_UP    = 4'h1,
    CMD_DOWN  = 4'h2,
    CMD_LEFT  = 4'h3,
    CMD_RIGHT = 4'h4,
    CMD_MAX   = 4'h5,
    CMD_MIN   = 4'h6,
    CMD_AVG   = 4'h7,
    CMD_CCW   = 4'h8,
    CMD_CW    = 4'h9,
    CMD_MIRX  = 4'hA,
    CMD_MIRY  = 4'hB
  } cmd_e;

  typedef enum logic [2:0] {
    LOAD,
    READY,
    EXEC,
    WRITE,
    DONE
  } state_e;

  // Window pixel (dx,dy) in {0,1}^2 relative to the top-left corner (x-1,y-1).
  function automatic int win_idx(int x, int y, int dx, int dy, int w);
    return (y - 1 + dy) * w + (x - 1 + dx);
  endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator.
//   cmd_i             : command code; 5..B modify the window, others pass through
//   tl_i/tr_i/bl_i/br_i : current window pixels
//   tl_o/tr_o/bl_o/br_o : new window pixels
module lcd_win_alu
  import lcd_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  cmd_e             cmd_i,
  input  logic [PIX_W-1:0] tl_i,
  input  logic [PIX_W-1:0] tr_i,
  input  logic [PIX_W-1:0] bl_i,
  input  logic [PIX_W-1:0] br_i,
  output logic [PIX_W-1:0] tl_o,
  output logic [PIX_W-1:0] tr_o,
  output logic [PIX_W-1:0] bl_o,
  output logic [PIX_W-1:0] br_o
);

  logic [PIX_W-1:0] mx_t, mx_b, mx, mn_t, mn_b, mn, avg;
  logic [PIX_W+1:0] sum;

  always_comb begin
    mx_t = (tl_i > tr_i) ? tl_i : tr_i;
    mx_b = (bl_i > br_i) ? bl_i : br_i;
    mx   = (mx_t > mx_b) ? mx_t : mx_b;
    mn_t = (tl_i < tr_i) ? tl_i : tr_i;
    mn_b = (bl_i < br_i) ? bl_i : br_i;
    mn   = (mn_t < mn_b) ? mn_t : mn_b;
    // Two guard bits hold the sum of four pixels without overflow.
    sum  = {2'b00, tl_i} + {2'b00, tr_i} + {2'b00, bl_i} + {2'b00, br_i};
    avg  = sum[PIX_W+1:2];

    tl_o = tl_i;
    tr_o = tr_i;
    bl_o = bl_i;
    br_o = br_i;
    case (cmd_i)
      CMD_MAX:  begin tl_o = mx;   tr_o = mx;   bl_o = mx;   br_o = mx;   end
      CMD_MIN:  begin tl_o = mn;   tr_o = mn;   bl_o = mn;   br_o = mn;   end
      CMD_AVG:  begin tl_o = avg;  tr_o = avg;  bl_o = avg;  br_o = avg;  end
      CMD_CCW:  begin tl_o = tr_i; tr_o = br_i; br_o = bl_i; bl_o = tl_i; end
      CMD_CW:   begin tl_o = bl_i; tr_o = tl_i; br_o = tr_i; bl_o = br_i; end
      CMD_MIRX: begin tl_o = bl_i; bl_o = tl_i; tr_o = br_i; br_o = tr_i; end
      CMD_MIRY: begin tl_o = tr_i; tr_o = tl_i; bl_o = br_i; br_o = bl_i; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Image display controller: loads IMG_W x IMG_H pixels from IROM, applies host
// commands to a 2x2 window at a movable op point, streams the buffer to IRAM.
//   clk, reset          : clock, async active-high reset
//   cmd, cmd_valid      : host command, taken only while busy=0
//   IROM_Q/IROM_rd/IROM_A : combinational-read ROM interface
//   IRAM_valid/IRAM_D/IRAM_A : RAM write interface
//   busy, done          : command backpressure, write-out complete pulse
module lcd_ctrl_param
  import lcd_pkg::*;
#(
  parameter  int IMG_W = 8,
  parameter  int IMG_H = 8,
  parameter  int PIX_W = 8,
  localparam int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  input  logic [PIX_W-1:0] IROM_Q,
  output logic             IROM_rd,
  output logic [AW-1:0]    IROM_A,
  output logic             IRAM_valid,
  output logic [PIX_W-1:0] IRAM_D,
  output logic [AW-1:0]    IRAM_A,
  output logic             busy,
  output logic             done
);

  localparam int N  = IMG_W*IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  cmd_e             cmd_q, cmd_d;
  logic [PIX_W-1:0] buf_q [N];

  logic             last;
  logic [AW-1:0]    a_tl, a_tr, a_bl, a_br;
  logic [PIX_W-1:0] n_tl, n_tr, n_bl, n_br;

  assign last = (cnt_q == AW'(N-1));
  assign a_tl = AW'(win_idx(int'(x_q), int'(y_q), 0, 0, IMG_W));
  assign a_tr = AW'(win_idx(int'(x_q), int'(y_q), 1, 0, IMG_W));
  assign a_bl = AW'(win_idx(int'(x_q), int'(y_q), 0, 1, IMG_W));
  assign a_br = AW'(win_idx(int'(x_q), int'(y_q), 1, 1, IMG_W));

  lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
    .cmd_i(cmd_q),
    .tl_i (buf_q[a_tl]), .tr_i(buf_q[a_tr]), .bl_i(buf_q[a_bl]), .br_i(buf_q[a_br]),
    .tl_o (n_tl),        .tr_o(n_tr),        .bl_o(n_bl),        .br_o(n_br)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      x_q     <= XW'(IMG_W/2);
      y_q     <= YW'(IMG_H/2);
      cmd_q   <= CMD_WRITE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    cmd_d   = cmd_q;
    case (state_q)
      LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d   = '0;
          state_d = READY;
        end
      end
      READY: begin
        if (cmd_valid) begin
          cmd_d   = cmd_e'(cmd);
          state_d = (cmd == CMD_WRITE) ? WRITE : EXEC;
        end
      end
      EXEC: begin
        state_d = READY;
        case (cmd_q)
          CMD_UP:    if (y_q > YW'(1))         y_d = y_q - 1'b1;
          CMD_DOWN:  if (y_q < YW'(IMG_H - 1)) y_d = y_q + 1'b1;
          CMD_LEFT:  if (x_q > XW'(1))         x_d = x_q - 1'b1;
          CMD_RIGHT: if (x_q < XW'(IMG_W - 1)) x_d = x_q + 1'b1;
          default:   ;
        endcase
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = READY;
      default: state_d = LOAD;
    endcase
  end

  // Image buffer. Window writes for non-ALU commands rewrite the same values.
  always_ff @(posedge clk) begin
    if (IROM_rd) begin
      buf_q[IROM_A] <= IROM_Q;
    end else if (state_q == EXEC) begin
      buf_q[a_tl] <= n_tl;
      buf_q[a_tr] <= n_tr;
      buf_q[a_bl] <= n_bl;
      buf_q[a_br] <= n_br;
    end
  end

  // Outputs
  always_comb begin
    IROM_rd    = 1'b0;
    IROM_A     = '0;
    IRAM_valid = 1'b0;
    IRAM_D     = '0;
    IRAM_A     = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      LOAD: begin
        // Held in LOAD during reset; the ROM read must stay off until release.
        IROM_rd = ~reset;
        IROM_A  = cnt_q;
      end
      READY: busy = 1'b0;
      WRITE: begin
        IRAM_valid = 1'b1;
        IRAM_A     = cnt_q;
        IRAM_D     = buf_q[cnt_q];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Scoreboard bench: 8x8 instance (u0) and 16x4 instance (u1), ROM[i]=i.
// Write commands push the expected IRAM stream; monitors pop on IRAM_valid.
module tb_lcd_ctrl_param;

  typedef struct {int a; int d;} exp_t;

  logic       clk, reset;
  logic [3:0] cmd_a  [2];
  logic       cv     [2];
  logic [7:0] rom_q  [2];
  logic       rd_w   [2];
  logic       vld_w  [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic [5:0] ra_w   [2];
  logic [5:0] wa_w   [2];
  logic [7:0] wd_w   [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   img [2][64];
  exp_t q0[$];
  exp_t q1[$];

  lcd_ctrl_param #(.IMG_W(8), .IMG_H(8), .PIX_W(8)) u0 (
    .clk(clk), .reset(reset), .cmd(cmd_a[0]), .cmd_valid(cv[0]), .IROM_Q(rom_q[0]),
    .IROM_rd(rd_w[0]), .IROM_A(ra_w[0]), .IRAM_valid(vld_w[0]), .IRAM_D(wd_w[0]),
    .IRAM_A(wa_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .PIX_W(8)) u1 (
    .clk(clk), .reset(reset), .cmd(cmd_a[1]), .cmd_valid(cv[1]), .IROM_Q(rom_q[1]),
    .IROM_rd(rd_w[1]), .IROM_A(ra_w[1]), .IRAM_valid(vld_w[1]), .IRAM_D(wd_w[1]),
    .IRAM_A(wa_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  assign rom_q[0] = {2'b00, ra_w[0]};
  assign rom_q[1] = {2'b00, ra_w[1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld_w[0]) begin
        chk("wr0_pending", int'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("iram_a0", wa_w[0], e.a);
          chk("iram_d0", wd_w[0], e.d);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld_w[1]) begin
        chk("wr1_pending", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("iram_a1", wa_w[1], e.a);
          chk("iram_d1", wd_w[1], e.d);
        end
      end
    end
  end

  // Called at a negedge. Checks busy length and done pulse; hold>=0 keeps
  // cmd_valid asserted with code 'hold' during the busy period.
  task automatic issue(int d, int c, int hold, int exp_busy);
    int t, nb, nd, dl;
    t = 0;
    while (busy_w[d] && t < 300) begin @(negedge clk); t++; end
    chk("idle_before_cmd", busy_w[d], 0);
    cmd_a[d] = 4'(c);
    cv[d]    = 1'b1;
    @(negedge clk);
    if (hold >= 0) cmd_a[d] = 4'(hold);
    else cv[d] = 1'b0;
    nb = 0; nd = 0; dl = 0;
    while (busy_w[d] && nb < 300) begin
      nb++;
      nd += int'(done_w[d]);
      dl = int'(done_w[d]);
      @(negedge clk);
    end
    cv[d] = 1'b0;
    chk("busy_len", nb, exp_busy);
    chk("done_cnt", nd, (exp_busy > 1) ? 1 : 0);
    if (exp_busy > 1) chk("done_last", dl, 1);
  endtask

  task automatic wr(int d);
    for (int k = 0; k < 64; k++) begin
      exp_t e;
      e.a = k;
      e.d = img[d][k];
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    issue(d, 0, -1, 65);
    chk("wr_drain", (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  // Called at a negedge with reset high; releases reset and checks the load walk.
  task automatic load_chk();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("rom_rd0", rd_w[0], 1);
      chk("rom_rd1", rd_w[1], 1);
      chk("rom_a0", ra_w[0], i);
      chk("rom_a1", ra_w[1], i);
      chk("busy0_load", busy_w[0], 1);
      @(negedge clk);
    end
    #1;
    chk("busy0_ready", busy_w[0], 0);
    chk("busy1_ready", busy_w[1], 0);
    chk("rom_rd0_off", rd_w[0], 0);
    for (int k = 0; k < 64; k++) begin
      img[0][k] = k;
      img[1][k] = k;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rom_rd", rd_w[0], 0);
    chk("rst_rom_a", ra_w[0], 0);
    chk("rst_iram_v", vld_w[0], 0);
    chk("rst_iram_d", wd_w[0], 0);
    chk("rst_iram_a", wa_w[0], 0);
    chk("rst_busy", busy_w[0], 1);
    chk("rst_done", done_w[0], 0);
    chk("rst_busy1", busy_w[1], 1);
    chk("rst_rom_rd1", rd_w[1], 0);
    load_chk();
  endtask

  task automatic set4(int d, int a0, int a1, int a2, int a3, int v);
    img[d][a0] = v; img[d][a1] = v; img[d][a2] = v; img[d][a3] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1;
    cv[0] = 1'b0; cv[1] = 1'b0;
    cmd_a[0] = '0; cmd_a[1] = '0;
    @(negedge clk);
    do_reset();

    // Identity image straight out
    wr(0);

    // Max at (4,4)
    issue(0, 5, -1, 1);
    set4(0, 27, 28, 35, 36, 36);
    wr(0);

    // Avg then Min at (4,4) on a fresh image
    do_reset();
    issue(0, 7, -1, 1);
    set4(0, 27, 28, 35, 36, 31);
    issue(0, 6, -1, 1);
    wr(0);

    // Move to (1,1) with clamping, rotate CW
    repeat (5) issue(0, 1, -1, 1);
    repeat (5) issue(0, 3, -1, 1);
    issue(0, 9, -1, 1);
    img[0][0] = 8; img[0][1] = 0; img[0][8] = 9; img[0][9] = 1;
    wr(0);

    // Clamp at (7,7): Max there touches 54,55,62,63
    repeat (10) issue(0, 2, -1, 1);
    repeat (10) issue(0, 4, -1, 1);
    issue(0, 5, -1, 1);
    set4(0, 54, 55, 62, 63, 63);
    wr(0);

    // Mirrors, then CCW+CW restore; Max held on cmd during busy is ignored
    do_reset();
    issue(0, 10, -1, 1);
    issue(0, 11, -1, 1);
    img[0][27] = 36; img[0][28] = 35; img[0][35] = 28; img[0][36] = 27;
    wr(0);
    issue(0, 8, 5, 1);
    issue(0, 9, -1, 1);
    issue(0, 12, -1, 1);
    issue(0, 15, -1, 1);
    wr(0);

    // Reset during write at k=20
    for (int k = 0; k < 64; k++) begin
      exp_t e;
      e.a = k;
      e.d = img[0][k];
      q0.push_back(e);
    end
    cmd_a[0] = 4'h0;
    cv[0]    = 1'b1;
    @(negedge clk);
    cv[0] = 1'b0;
    t = 0;
    while (!(vld_w[0] && wa_w[0] == 6'd20) && t < 100) begin @(negedge clk); t++; end
    chk("wr_reach_k20", int'(vld_w[0] && wa_w[0] == 6'd20), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_iram_v", vld_w[0], 0);
    chk("abort_busy", busy_w[0], 1);
    q0.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_done", done_w[0], 0);
      chk("abort_iram_v2", vld_w[0], 0);
    end
    load_chk();
    issue(0, 5, -1, 1);
    set4(0, 27, 28, 35, 36, 36);
    wr(0);

    // 16x4 instance: default (8,2), Down clamps at y=3, Max at (8,3)
    repeat (3) issue(1, 2, -1, 1);
    issue(1, 5, -1, 1);
    set4(1, 39, 40, 55, 56, 56);
    wr(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
